hazard_unit: RTL and testbench
==============================

// Module: hazard_unit
// PURPOSE
//   Pipeline hazard controller: produces stall/flush controls for the hazards that
//   operand forwarding alone cannot resolve. Covers load-use RAW, multi-cycle EX ops
//   (div/rem) and EX-stage control-flow redirects. Sits beside the forwarding logic;
//   drives PC, IF/ID, ID/EX and EX/MEM register enables/clears. Also counts stall cycles.
// PARAMETERS
//   NUM_REGS    32  architectural register count; address width = $clog2(NUM_REGS)
//   MC_TIMEOUT  64  max cycles in MC_BUSY before watchdog abort (>= 2)
//   CNT_W       32  width of stall-cycle counter
// PORTS
//   i_clk               in   1       clock, all state on rising edge
//   i_rst               in   1       reset, synchronous, active-high
//   i_ifid_rs1_addr     in   AW      rs1 of instruction in IF/ID
//   i_ifid_rs2_addr     in   AW      rs2 of instruction in IF/ID
//   i_ifid_uses_rs1     in   1       IF/ID instruction reads rs1
//   i_ifid_uses_rs2     in   1       IF/ID instruction reads rs2
//   i_idex_rd_addr      in   AW      rd of instruction in ID/EX
//   i_idex_mem_re       in   1       ID/EX instruction is a load
//   i_idex_valid        in   1       ID/EX holds a live instruction
//   i_ex_mc_start       in   1       EX instruction is multi-cycle (level, while in EX)
//   i_ex_mc_done        in   1       multi-cycle unit result valid this cycle
//   i_ex_redirect       in   1       EX resolves taken branch/jump/trap redirect
//   o_pc_stall          out  1       hold PC
//   o_ifid_stall        out  1       hold IF/ID
//   o_ifid_flush        out  1       clear IF/ID to bubble
//   o_idex_stall        out  1       hold ID/EX
//   o_idex_flush        out  1       clear ID/EX to bubble
//   o_exmem_flush       out  1       write bubble into EX/MEM
//   o_mc_timeout        out  1       one-cycle pulse: watchdog abort
//   o_stall_cycles      out  CNT_W   saturating count of cycles with o_pc_stall=1
// BEHAVIOUR
//   - Reset: state=RUN, watchdog=0, o_stall_cycles=0, o_mc_timeout=0; all stall/flush
//     outputs 0 in the reset cycle regardless of inputs.
//   - States: RUN, MC_BUSY. Stall/flush outputs are combinational from state + inputs.
//   - Priority per cycle: redirect > multi-cycle > load-use.
//   - Redirect (i_ex_redirect=1, state RUN): o_ifid_flush=1, o_idex_flush=1, no stalls;
//     load-use and mc_start ignored that cycle; state stays RUN.
//   - Multi-cycle, RUN: i_ex_mc_start=1 & !i_ex_mc_done -> assert o_pc_stall, o_ifid_stall,
//     o_idex_stall, o_exmem_flush; next state MC_BUSY, watchdog=1.
//     mc_start & mc_done same cycle -> no stall, stay RUN.
//   - MC_BUSY: same four outputs asserted while !i_ex_mc_done; watchdog +1 per cycle.
//     i_ex_mc_done=1 -> outputs deasserted that cycle (result flows to EX/MEM), next RUN.
//     i_ex_redirect ignored in MC_BUSY.
//   - Watchdog: in MC_BUSY with watchdog==MC_TIMEOUT-1 and !done -> o_mc_timeout=1
//     next cycle, state -> RUN; o_exmem_flush=1 and stalls released in the abort cycle.
//   - Load-use (RUN, no redirect, no mc stall): i_idex_valid & i_idex_mem_re &
//     i_idex_rd_addr!=0 & ((uses_rs1 & rs1==rd) | (uses_rs2 & rs2==rd)) ->
//     o_pc_stall=1, o_ifid_stall=1, o_idex_flush=1 for exactly that cycle; no state.
//     Next cycle the load is in EX/MEM and forwarding resolves the dependency.
//   - Stall/flush of the same stage never both 1 except o_idex_stall/o_idex_flush,
//     which are mutually exclusive by construction.
//   - o_stall_cycles: +1 on each cycle o_pc_stall=1; saturates at all-ones.
//   - Reset mid-MC_BUSY: next cycle RUN, counters zeroed, no timeout pulse.
// TESTING
//   Load-use: idex load rd=5, ifid rs1=5 uses_rs1 -> 1 cycle pc/ifid stall + idex_flush; count=1.
//   rd=0 or uses_rs*=0 or idex_valid=0 with rs1=rd -> no stall, count unchanged.
//   Redirect + load-use same cycle -> ifid_flush=idex_flush=1, pc_stall=0.
//   mc_start, done after 5 cycles -> stalls+exmem_flush 5 cycles, released on done; count=5.
//   mc_start, done never, MC_TIMEOUT=4 -> stalls 4 cycles, o_mc_timeout pulse, state RUN.
//   i_rst during MC_BUSY cycle 2 -> next cycle all outputs 0, o_stall_cycles=0.

Source files
------------

// File: rtl/hazard_unit_if.sv
// ---------------------------------------------------------------------------
// hazard_unit_if
//   Bundles the pipeline-side hazard signals seen by hazard_unit.
//   Ports (all members are plain logic):
//     i_ifid_rs1_addr/i_ifid_rs2_addr  [AW]  source registers of IF/ID instr
//     i_ifid_uses_rs1/i_ifid_uses_rs2        IF/ID instr actually reads them
//     i_idex_rd_addr                   [AW]  destination of ID/EX instr
//     i_idex_mem_re, i_idex_valid            ID/EX instr is a live load
//     i_ex_mc_start, i_ex_mc_done            multi-cycle EX op handshake
//     i_ex_redirect                          EX resolves a control-flow change
//     o_* stall/flush controls, o_mc_timeout pulse, o_stall_cycles [CNT_W]
//   Modports: master = pipeline side, slave = hazard_unit.
// ---------------------------------------------------------------------------
interface hazard_unit_if #(
   parameter int AW    = 5,
   parameter int CNT_W = 32
);
   logic [AW-1:0]    i_ifid_rs1_addr;
   logic [AW-1:0]    i_ifid_rs2_addr;
   logic             i_ifid_uses_rs1;
   logic             i_ifid_uses_rs2;
   logic [AW-1:0]    i_idex_rd_addr;
   logic             i_idex_mem_re;
   logic             i_idex_valid;
   logic             i_ex_mc_start;
   logic             i_ex_mc_done;
   logic             i_ex_redirect;
   logic             o_pc_stall;
   logic             o_ifid_stall;
   logic             o_ifid_flush;
   logic             o_idex_stall;
   logic             o_idex_flush;
   logic             o_exmem_flush;
   logic             o_mc_timeout;
   logic [CNT_W-1:0] o_stall_cycles;

   modport master (
      output i_ifid_rs1_addr, i_ifid_rs2_addr, i_ifid_uses_rs1, i_ifid_uses_rs2,
             i_idex_rd_addr, i_idex_mem_re, i_idex_valid,
             i_ex_mc_start, i_ex_mc_done, i_ex_redirect,
      input  o_pc_stall, o_ifid_stall, o_ifid_flush, o_idex_stall, o_idex_flush,
             o_exmem_flush, o_mc_timeout, o_stall_cycles
   );

   modport slave (
      input  i_ifid_rs1_addr, i_ifid_rs2_addr, i_ifid_uses_rs1, i_ifid_uses_rs2,
             i_idex_rd_addr, i_idex_mem_re, i_idex_valid,
             i_ex_mc_start, i_ex_mc_done, i_ex_redirect,
      output o_pc_stall, o_ifid_stall, o_ifid_flush, o_idex_stall, o_idex_flush,
             o_exmem_flush, o_mc_timeout, o_stall_cycles
   );
endinterface

// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
//   Stall/flush controller for hazards forwarding cannot cover: load-use RAW,
//   multi-cycle EX operations (with a watchdog) and EX-stage redirects.
//   Also keeps a saturating count of cycles in which the PC was held.
//   Ports:
//     i_clk  clock, all state on the rising edge
//     i_rst  synchronous active-high reset
//     bus    hazard_unit_if.slave carrying pipeline inputs and control outputs
//   Priority each cycle: redirect > multi-cycle > load-use.
// ---------------------------------------------------------------------------
module hazard_unit #(
   parameter int NUM_REGS   = 32,
   parameter int MC_TIMEOUT = 64,
   parameter int CNT_W      = 32
) (
   input logic          i_clk,
   input logic          i_rst,
   hazard_unit_if.slave bus
);
   localparam int AW  = $clog2(NUM_REGS);
   localparam int WDW = $clog2(MC_TIMEOUT + 1);

   typedef enum logic {
      RUN,
      MC_BUSY
   } state_t;

   state_t           state;
   logic [WDW-1:0]   watchdog;
   logic             timeout_q;
   logic [CNT_W-1:0] stall_cnt;

   logic load_use;
   logic start_mc;
   logic pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_flush;

   // A load in ID/EX whose destination is read by the IF/ID instruction;
   // x0 is never a real dependency.
   assign load_use = bus.i_idex_valid && bus.i_idex_mem_re &&
                     (bus.i_idex_rd_addr != AW'(0)) &&
                     ((bus.i_ifid_uses_rs1 && (bus.i_ifid_rs1_addr == bus.i_idex_rd_addr)) ||
                      (bus.i_ifid_uses_rs2 && (bus.i_ifid_rs2_addr == bus.i_idex_rd_addr)));

   // Control outputs are combinational from state and inputs. The cycle right
   // after a watchdog abort (timeout_q) bubbles EX/MEM and ignores mc_start,
   // since the instruction still sitting in EX is the one being abandoned.
   always_comb begin
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      ifid_flush  = 1'b0;
      idex_stall  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      start_mc    = 1'b0;
      if (!i_rst) begin
         if (state == MC_BUSY) begin
            if (!bus.i_ex_mc_done) begin
               pc_stall    = 1'b1;
               ifid_stall  = 1'b1;
               idex_stall  = 1'b1;
               exmem_flush = 1'b1;
            end
         end else begin
            if (timeout_q) begin
               exmem_flush = 1'b1;
            end
            if (bus.i_ex_redirect) begin
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
            end else if (bus.i_ex_mc_start && !bus.i_ex_mc_done && !timeout_q) begin
               pc_stall    = 1'b1;
               ifid_stall  = 1'b1;
               idex_stall  = 1'b1;
               exmem_flush = 1'b1;
               start_mc    = 1'b1;
            end else if (load_use) begin
               pc_stall   = 1'b1;
               ifid_stall = 1'b1;
               idex_flush = 1'b1;
            end
         end
      end
   end

   // State, watchdog and stall counter. The watchdog holds the number of
   // stall cycles already spent on the current multi-cycle op; when the last
   // permitted cycle passes without done, the op is abandoned and a one-cycle
   // timeout pulse follows.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= RUN;
         watchdog  <= '0;
         timeout_q <= 1'b0;
         stall_cnt <= '0;
      end else begin
         timeout_q <= 1'b0;
         if (pc_stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         case (state)
            RUN: begin
               if (start_mc) begin
                  state    <= MC_BUSY;
                  watchdog <= WDW'(1);
               end
            end
            MC_BUSY: begin
               if (bus.i_ex_mc_done) begin
                  state    <= RUN;
                  watchdog <= '0;
               end else if (watchdog == WDW'(MC_TIMEOUT - 1)) begin
                  state     <= RUN;
                  watchdog  <= '0;
                  timeout_q <= 1'b1;
               end else begin
                  watchdog <= watchdog + WDW'(1);
               end
            end
            default: begin
               state    <= RUN;
               watchdog <= '0;
            end
         endcase
      end
   end

   assign bus.o_pc_stall     = pc_stall;
   assign bus.o_ifid_stall   = ifid_stall;
   assign bus.o_ifid_flush   = ifid_flush;
   assign bus.o_idex_stall   = idex_stall;
   assign bus.o_idex_flush   = idex_flush;
   assign bus.o_exmem_flush  = exmem_flush;
   assign bus.o_mc_timeout   = timeout_q && !i_rst;
   assign bus.o_stall_cycles = stall_cnt;
endmodule

// File: tb/tb_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_unit
//   Drives two hazard_unit instances with identical stimulus: one with a short
//   watchdog and narrow counter (MC_TIMEOUT=4, CNT_W=4), one with defaults.
//   Expected outputs come from a rule-level model and go through queues to an
//   independent monitor.
// ---------------------------------------------------------------------------
module tb_hazard_unit;
   localparam int AW = 5;

   typedef struct packed {
      logic [6:0]  ctl;
      logic [31:0] cnt;
   } exp_t;

   logic i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   logic          rst = 1'b1;
   logic [AW-1:0] rs1 = '0, rs2 = '0, rd = '0;
   logic          u1 = 1'b0, u2 = 1'b0, mem_re = 1'b0, idex_valid = 1'b0;
   logic          mc_start = 1'b0, mc_done = 1'b0, redirect = 1'b0;

   int total = 0;
   int bad   = 0;

   exp_t q_a[$];
   exp_t q_b[$];

   hazard_unit_if #(.AW(AW), .CNT_W(4))  bus_a();
   hazard_unit_if #(.AW(AW), .CNT_W(32)) bus_b();

   assign bus_a.i_ifid_rs1_addr = rs1;
   assign bus_a.i_ifid_rs2_addr = rs2;
   assign bus_a.i_ifid_uses_rs1 = u1;
   assign bus_a.i_ifid_uses_rs2 = u2;
   assign bus_a.i_idex_rd_addr  = rd;
   assign bus_a.i_idex_mem_re   = mem_re;
   assign bus_a.i_idex_valid    = idex_valid;
   assign bus_a.i_ex_mc_start   = mc_start;
   assign bus_a.i_ex_mc_done    = mc_done;
   assign bus_a.i_ex_redirect   = redirect;
   assign bus_b.i_ifid_rs1_addr = rs1;
   assign bus_b.i_ifid_rs2_addr = rs2;
   assign bus_b.i_ifid_uses_rs1 = u1;
   assign bus_b.i_ifid_uses_rs2 = u2;
   assign bus_b.i_idex_rd_addr  = rd;
   assign bus_b.i_idex_mem_re   = mem_re;
   assign bus_b.i_idex_valid    = idex_valid;
   assign bus_b.i_ex_mc_start   = mc_start;
   assign bus_b.i_ex_mc_done    = mc_done;
   assign bus_b.i_ex_redirect   = redirect;

   hazard_unit #(.NUM_REGS(32), .MC_TIMEOUT(4), .CNT_W(4)) dut_a (
      .i_clk (i_clk),
      .i_rst (rst),
      .bus   (bus_a)
   );

   hazard_unit #(.NUM_REGS(32), .MC_TIMEOUT(64), .CNT_W(32)) dut_b (
      .i_clk (i_clk),
      .i_rst (rst),
      .bus   (bus_b)
   );

   // Reference model state, index 0 = dut_a, 1 = dut_b.
   bit     m_busy[2]    = '{0, 0};
   int     m_elapsed[2] = '{0, 0};
   bit     m_abort[2]   = '{0, 0};
   longint m_cnt[2]     = '{0, 0};
   int     m_tmo[2]     = '{4, 64};
   longint m_max[2]     = '{15, 64'h0000_0000_FFFF_FFFF};

   // Control bit order: pc_stall ifid_stall ifid_flush idex_stall idex_flush
   // exmem_flush mc_timeout. Produces this cycle's outputs from the current
   // inputs and advances the model to the next cycle.
   function automatic exp_t modelStep(int v);
      exp_t       e;
      logic [6:0] c;
      bit         lu;
      bit         ab;
      c     = 7'b0;
      e.cnt = 32'(m_cnt[v]);
      lu = idex_valid && mem_re && (rd != 0) &&
           ((u1 && (rs1 == rd)) || (u2 && (rs2 == rd)));
      if (rst) begin
         m_busy[v]    = 0;
         m_elapsed[v] = 0;
         m_abort[v]   = 0;
         m_cnt[v]     = 0;
      end else if (m_busy[v]) begin
         if (mc_done) begin
            m_busy[v] = 0;
         end else begin
            c = 7'b1101010;
            m_elapsed[v] = m_elapsed[v] + 1;
            if (m_elapsed[v] == m_tmo[v]) begin
               m_busy[v]  = 0;
               m_abort[v] = 1;
            end
         end
      end else begin
         ab         = m_abort[v];
         m_abort[v] = 0;
         c[1]       = ab;
         c[0]       = ab;
         if (redirect) begin
            c[4] = 1'b1;
            c[2] = 1'b1;
         end else if (mc_start && !mc_done && !ab) begin
            c            = c | 7'b1101010;
            m_busy[v]    = 1;
            m_elapsed[v] = 1;
         end else if (lu) begin
            c = c | 7'b1100100;
         end
      end
      if (c[6] && (m_cnt[v] < m_max[v])) m_cnt[v] = m_cnt[v] + 1;
      e.ctl = c;
      return e;
   endfunction

   // Drives one cycle of inputs just after the rising edge and queues the
   // outputs both instances should present during that cycle.
   task automatic applyStimulus(input logic r, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                                input logic [AW-1:0] d, input logic uu1, input logic uu2,
                                input logic mre, input logic vld, input logic ms,
                                input logic md, input logic rdr);
      @(posedge i_clk);
      #1;
      rst = r; rs1 = a1; rs2 = a2; rd = d; u1 = uu1; u2 = uu2;
      mem_re = mre; idex_valid = vld; mc_start = ms; mc_done = md; redirect = rdr;
      q_a.push_back(modelStep(0));
      q_b.push_back(modelStep(1));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("[TB] FAIL %s got=%h want=%h at %0t", name, act, want, $time);
      end
   endtask

   // Monitor: every cycle with queued expectations, compare both instances.
   always @(negedge i_clk) begin
      exp_t ea;
      exp_t eb;
      if (q_a.size() > 0 && q_b.size() > 0) begin
         ea = q_a.pop_front();
         eb = q_b.pop_front();
         checkOutput("ctl_a", 32'({bus_a.o_pc_stall, bus_a.o_ifid_stall, bus_a.o_ifid_flush,
                                   bus_a.o_idex_stall, bus_a.o_idex_flush, bus_a.o_exmem_flush,
                                   bus_a.o_mc_timeout}), 32'(ea.ctl));
         checkOutput("cnt_a", 32'(bus_a.o_stall_cycles), ea.cnt);
         checkOutput("ctl_b", 32'({bus_b.o_pc_stall, bus_b.o_ifid_stall, bus_b.o_ifid_flush,
                                   bus_b.o_idex_stall, bus_b.o_idex_flush, bus_b.o_exmem_flush,
                                   bus_b.o_mc_timeout}), 32'(eb.ctl));
         checkOutput("cnt_b", 32'(bus_b.o_stall_cycles), eb.cnt);
      end
   end

   initial begin
      $display("[TB] start");
      // reset, with a hazard present on the inputs to prove outputs stay low
      applyStimulus(1, 5, 0, 5, 1, 0, 1, 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);

      // load-use on rs1, then on rs2
      applyStimulus(0, 5, 0, 5, 1, 0, 1, 1, 0, 0, 0);
      idle(1);
      @(negedge i_clk);
      checkOutput("lu_count", bus_b.o_stall_cycles, 32'd1);
      applyStimulus(0, 1, 7, 7, 0, 1, 1, 1, 0, 0, 0);

      // no-hazard variants: rd=0, uses_rs1=0, idex_valid=0, not a load
      applyStimulus(0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0);
      applyStimulus(0, 5, 0, 5, 0, 0, 1, 1, 0, 0, 0);
      applyStimulus(0, 5, 0, 5, 1, 0, 1, 0, 0, 0, 0);
      applyStimulus(0, 5, 0, 5, 1, 0, 0, 1, 0, 0, 0);

      // redirect wins over load-use and mc_start
      applyStimulus(0, 5, 0, 5, 1, 0, 1, 1, 0, 0, 1);
      applyStimulus(0, 5, 0, 5, 1, 0, 1, 1, 1, 0, 1);
      idle(1);
      @(negedge i_clk);
      checkOutput("nohaz_count", bus_b.o_stall_cycles, 32'd2);

      // multi-cycle op finishing after five stall cycles; start+done together
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      idle(1);
      @(negedge i_clk);
      checkOutput("mc_count", bus_b.o_stall_cycles, 32'd5);

      // multi-cycle op that never completes (dut_a watchdog fires)
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      applyStimulus(0, 3, 0, 3, 1, 0, 1, 1, 0, 1, 0);
      idle(2);

      // reset arriving in the second busy cycle
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      idle(1);
      @(negedge i_clk);
      checkOutput("rst_count", bus_b.o_stall_cycles, 32'd0);

      // randomized traffic; small register set makes hits frequent
      for (int i = 0; i < 800; i++) begin
         applyStimulus(1'($urandom_range(0, 63) == 0),
                       AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
                       AW'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                       1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 4) == 0),
                       1'($urandom_range(0, 7) == 0));
      end
      idle(2);
      repeat (2) @(negedge i_clk);
      checkOutput("drain_a", 32'(q_a.size()), 32'd0);
      checkOutput("drain_b", 32'(q_b.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
